digit_entry_ctrl: RTL

Board-level controller that sequences 16-bit value entry from the 4-bit switch bank, one nibble per debounced button press, MSB digit first. It replaces the one-shot, button-clocked latch with a fully synchronous entry state machine. It presents a live 16-bit preview for the seven-segment driver and offers the finished value to the CPU-side I/O register through a valid/ready handshake.

---
 rtl/digit_entry_ctrl_pkg.sv | 30 +++
 rtl/digit_entry_ctrl_if.sv | 13 +
 rtl/digit_entry_ctrl_btn_debounce.sv | 54 +++++
 rtl/digit_entry_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/digit_entry_ctrl_pkg.sv
// Shared types and constants for the digit entry controller.
// Package name: dev_entry_pkg.
package dev_entry_pkg;

   localparam int NIBBLES = 4;
   localparam int DIGIT_W = 2;
   localparam int NIB_W   = 4;
   localparam int DATA_W  = NIBBLES * NIB_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENTRY = 2'd1,
      OFFER = 2'd2
   } state_t;

   typedef logic [DIGIT_W-1:0] digit_idx_t;

   localparam digit_idx_t DIGIT_TOP = digit_idx_t'(NIBBLES - 1);

   // Replace one nibble of the working value, leaving the others untouched.
   function automatic logic [DATA_W-1:0] set_nibble(input logic [DATA_W-1:0] data,
                                                    input digit_idx_t        idx,
                                                    input logic [NIB_W-1:0]  nib);
      logic [DATA_W-1:0] res;
      res = data;
      res[idx*NIB_W +: NIB_W] = nib;
      return res;
   endfunction

endpackage

// File: rtl/digit_entry_ctrl_if.sv
// Commit handshake between the entry controller and the CPU-side register.
// master = controller (offers the value), slave = consumer.
interface digit_entry_ctrl_if;
   import dev_entry_pkg::*;

   logic              commit_valid;
   logic [DATA_W-1:0] commit_data;
   logic              commit_ready;

   modport master (output commit_valid, output commit_data, input commit_ready);
   modport slave  (input commit_valid, input commit_data, output commit_ready);

endinterface

// File: rtl/digit_entry_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
// The debounced level only changes after the synchronised level has differed
// from it for DEBOUNCE_CYCLES consecutive samples.
module btn_debounce
   import dev_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_s1;
   logic             r_s2;
   logic             r_level;
   logic             r_level_d;
   logic             r_pulse;
   logic [CNT_W-1:0] r_cnt;

   // Synchronise, qualify the level for stability, and emit one pulse per rise
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_pulse   <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_s1      <= i_btn;
         r_s2      <= r_s1;
         r_level_d <= r_level;
         r_pulse   <= r_level & ~r_level_d;
         if (r_s2 != r_level) begin
            if (r_cnt == CNT_LAST) begin
               r_level <= r_s2;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/digit_entry_ctrl.sv
// Sequenced 16-bit value entry from a 4-bit switch bank, MSB digit first,
// with a live preview and a valid/ready commit towards the CPU side.
// Optional build macro INPUT_TIMEOUT_EN adds an inactivity abort in ENTRY;
// without it the timeout output is tied low.
module digit_entry_ctrl
   import dev_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int TIMEOUT_CYCLES  = 500_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NIB_W-1:0]    i_sw,
   input  logic                i_btn_next,
   input  logic                i_btn_clear,
   output logic [DATA_W-1:0]   o_entry_data,
   output logic [DIGIT_W-1:0]  o_digit_sel,
   output logic                o_entry_active,
   output logic                o_timeout,
   digit_entry_ctrl_if.master  commit
);

   state_t            r_state;
   logic [NIB_W-1:0]  r_sw_s1;
   logic [NIB_W-1:0]  r_sw_s2;
   logic [DATA_W-1:0] r_entry_data;
   digit_idx_t        r_digit_sel;
   logic              r_entry_active;
   logic              r_commit_valid;
   logic [DATA_W-1:0] r_commit_data;
   logic              r_timeout;

   logic              w_next_p;
   logic              w_clear_p;
   logic              w_to_expire;
   logic [DATA_W-1:0] w_entry_live;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (i_btn_next),
      .o_pulse (w_next_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (i_btn_clear),
      .o_pulse (w_clear_p)
   );

   // Bring the switch nibble into the clock domain
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sw_s1 <= '0;
         r_sw_s2 <= '0;
      end else begin
         r_sw_s1 <= i_sw;
         r_sw_s2 <= r_sw_s1;
      end
   end

   // Working value with the digit under edit replaced by the live switches
   assign w_entry_live = set_nibble(r_entry_data, r_digit_sel, r_sw_s2);

`ifdef INPUT_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] r_to_cnt;

   // Inactivity counter: held at zero outside ENTRY, restarted by every press
   always_ff @(posedge clk) begin
      if (rst || (r_state != ENTRY) || w_next_p || w_clear_p || w_to_expire) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   assign w_to_expire = (r_state == ENTRY) && (r_to_cnt == TO_LAST) && !w_next_p;
`else
   // No inactivity limit; the parameter is accepted but has no effect
   assign w_to_expire = (TIMEOUT_CYCLES < 0);
`endif

   // Entry state machine with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_entry_data   <= '0;
         r_digit_sel    <= DIGIT_TOP;
         r_entry_active <= 1'b0;
         r_commit_valid <= 1'b0;
         r_commit_data  <= '0;
         r_timeout      <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_next_p) begin
                  r_entry_data   <= '0;
                  r_digit_sel    <= DIGIT_TOP;
                  r_entry_active <= 1'b1;
                  r_state        <= ENTRY;
               end else if (w_clear_p) begin
                  r_entry_data <= '0;
               end
            end
            ENTRY: begin
               if (w_clear_p || w_to_expire) begin
                  // Clear (or inactivity) beats a simultaneous next press
                  r_entry_data   <= '0;
                  r_digit_sel    <= DIGIT_TOP;
                  r_entry_active <= 1'b0;
                  r_timeout      <= w_to_expire & ~w_clear_p;
                  r_state        <= IDLE;
               end else begin
                  r_entry_data <= w_entry_live;
                  if (w_next_p) begin
                     if (r_digit_sel != '0) begin
                        r_digit_sel <= r_digit_sel - digit_idx_t'(1);
                     end else begin
                        r_commit_data  <= w_entry_live;
                        r_commit_valid <= 1'b1;
                        r_entry_active <= 1'b0;
                        r_state        <= OFFER;
                     end
                  end
               end
            end
            OFFER: begin
               // Buttons are ignored; only acceptance leaves this state
               if (r_commit_valid && commit.commit_ready) begin
                  r_commit_valid <= 1'b0;
                  r_digit_sel    <= DIGIT_TOP;
                  r_state        <= IDLE;
               end
            end
            default: begin
               r_state        <= IDLE;
               r_entry_active <= 1'b0;
               r_commit_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_entry_data        = r_entry_data;
   assign o_digit_sel         = r_digit_sel;
   assign o_entry_active      = r_entry_active;
   assign o_timeout           = r_timeout;
   assign commit.commit_valid = r_commit_valid;
   assign commit.commit_data  = r_commit_data;

endmodule
